// File: rtl/modn_pkg.sv
// Shared types and helpers for the mod-N sequencing controller.
package modn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned MIN_N = 2;

    // A config is usable when the modulus is in range and a one-shot run has work to do.
    function automatic logic cfg_ok(input int unsigned n, input int unsigned max_n,
                                    input logic oneshot, input int unsigned reps);
        return (n >= MIN_N) && (n <= max_n) && !(oneshot && (reps == 0));
    endfunction

endpackage

// File: rtl/modn_core.sv
// Mod-N count register: synchronous clear, advances on en, wraps at n-1.
module modn_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH:0]   n,
    output logic [WIDTH-1:0] count,
    output logic             wrap_c
);

    logic [WIDTH:0] last;

    // Compare in WIDTH+1 bits so n = 2**WIDTH gives a terminal count of all-ones.
    assign last   = n - (WIDTH+1)'(1);
    assign wrap_c = en && ({1'b0, count} == last);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap_c ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/modn_seq_ctrl.sv
// Run-time controller for a mod-N counter: config handshake, start/pause/stop, wrap tracking.
// Optional prescaler enabled by defining MODN_SEQ_PRESCALE_EN.
module modn_seq_ctrl
    import modn_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DEFAULT_N = 12,
    parameter int unsigned REP_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH:0]   cfg_n,
    input  logic [REP_W-1:0] cfg_reps,
    input  logic             cfg_oneshot,
`ifdef MODN_SEQ_PRESCALE_EN
    input  logic [7:0]       cfg_div,
`endif
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic [REP_W-1:0] wraps,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    localparam int unsigned MAX_N = 2**WIDTH;

    state_t           state, st_nxt;
    logic [WIDTH:0]   n_reg;
    logic [REP_W-1:0] reps_reg, wraps_nxt;
    logic             oneshot_reg;
    logic             rdy, cfg_hit, cfg_good, cfg_acc;
    logic             run_adv, step, clr, wrap_c;

    assign rdy      = (state == IDLE) || (state == DONE);
    assign cfg_hit  = cfg_valid && rdy;
    assign cfg_good = cfg_ok(32'(cfg_n), MAX_N, cfg_oneshot, 32'(cfg_reps));
    assign cfg_acc  = cfg_hit && cfg_good;
    assign run_adv  = (state == RUN) && !stop && !pause;

`ifdef MODN_SEQ_PRESCALE_EN
    logic [7:0] div_reg, pre_cnt;
    logic       pre_hit;

    assign pre_hit = (pre_cnt == div_reg);
    assign step    = run_adv && pre_hit;

    // Prescaler only moves on advancing RUN cycles, so it freezes through HOLD.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_reg <= '0;
            pre_cnt <= '0;
        end else begin
            if (cfg_acc) div_reg <= cfg_div;
            if (clr) begin
                pre_cnt <= '0;
            end else if (run_adv) begin
                pre_cnt <= pre_hit ? '0 : pre_cnt + 8'd1;
            end
        end
    end
`else
    assign step = run_adv;
`endif

    modn_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .reset  (reset),
        .en     (step),
        .clr    (clr),
        .n      (n_reg),
        .count  (count),
        .wrap_c (wrap_c)
    );

    // Next state, wrap counter and datapath clear; stop > pause > start, config beats start.
    always_comb begin
        st_nxt    = state;
        wraps_nxt = wraps;
        clr       = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (cfg_acc || stop) begin
                    st_nxt    = IDLE;
                    clr       = 1'b1;
                    wraps_nxt = '0;
                end else if (!pause && start) begin
                    st_nxt    = RUN;
                    clr       = 1'b1;
                    wraps_nxt = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    st_nxt    = IDLE;
                    clr       = 1'b1;
                    wraps_nxt = '0;
                end else if (pause) begin
                    st_nxt = HOLD;
                end else if (wrap_c) begin
                    wraps_nxt = (&wraps) ? wraps : wraps + REP_W'(1);
                    if (oneshot_reg && (wraps_nxt == reps_reg)) st_nxt = DONE;
                end
            end
            HOLD: begin
                if (stop) begin
                    st_nxt    = IDLE;
                    clr       = 1'b1;
                    wraps_nxt = '0;
                end else if (!pause && start) begin
                    st_nxt = RUN;
                end
            end
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            wraps       <= '0;
            tick        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cfg_ready   <= 1'b1;
            cfg_err     <= 1'b0;
            n_reg       <= (WIDTH+1)'(DEFAULT_N);
            reps_reg    <= '0;
            oneshot_reg <= 1'b0;
        end else begin
            state     <= st_nxt;
            wraps     <= wraps_nxt;
            tick      <= wrap_c;
            busy      <= (st_nxt == RUN) || (st_nxt == HOLD);
            done      <= (st_nxt == DONE);
            cfg_ready <= (st_nxt == IDLE) || (st_nxt == DONE);
            cfg_err   <= cfg_hit && !cfg_good;
            if (cfg_acc) begin
                n_reg       <= cfg_n;
                reps_reg    <= cfg_reps;
                oneshot_reg <= cfg_oneshot;
            end
        end
    end

endmodule

// File: tb/tb_modn_seq_ctrl.sv
// Directed bench for modn_seq_ctrl with hand-computed expectations.
module tb_modn_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_valid, cfg_ready, cfg_oneshot;
    logic [4:0] cfg_n;
    logic [7:0] cfg_reps;
    logic [7:0] cfg_div;
    logic       start, pause, stop;
    logic [3:0] count;
    logic       tick, busy, done, cfg_err;
    logic [7:0] wraps;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    modn_seq_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_n       (cfg_n),
        .cfg_reps    (cfg_reps),
        .cfg_oneshot (cfg_oneshot),
`ifdef MODN_SEQ_PRESCALE_EN
        .cfg_div     (cfg_div),
`endif
        .start       (start),
        .pause       (pause),
        .stop        (stop),
        .count       (count),
        .tick        (tick),
        .wraps       (wraps),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [4:0] n, input logic [7:0] reps, input logic os);
        cfg_valid   = 1'b1;
        cfg_n       = n;
        cfg_reps    = reps;
        cfg_oneshot = os;
    endtask

    initial begin
        reset = 1'b0; cfg_valid = 1'b0; cfg_n = '0; cfg_reps = '0; cfg_oneshot = 1'b0;
        cfg_div = '0; start = 1'b0; pause = 1'b0; stop = 1'b0;
        cyc(2);
        chk("rst_count", 32'(count), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_wraps", 32'(wraps), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(cfg_err), 0);
        chk("rst_ready", 32'(cfg_ready), 1);
        reset = 1'b1;
        cyc(1);

        // Default modulus 12: 0..11 then a tick at 0
        start = 1'b1; cyc(1); start = 1'b0;
        chk("def_busy", 32'(busy), 1);
        chk("def_c0", 32'(count), 0);
        for (int k = 1; k <= 11; k++) begin
            cyc(1);
            chk("def_count", 32'(count), 32'(k));
            chk("def_notick", 32'(tick), 0);
        end
        cyc(1);
        chk("def_wrap_count", 32'(count), 0);
        chk("def_tick", 32'(tick), 1);
        chk("def_wraps", 32'(wraps), 1);
        chk("def_done", 32'(done), 0);
        cyc(1);
        chk("def_tick_off", 32'(tick), 0);

        // Pause at 7 for 3 edges, resume edge, then 8
        cyc(6);
        chk("pre_pause", 32'(count), 7);
        pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk("hold_count", 32'(count), 7);
            chk("hold_tick", 32'(tick), 0);
        end
        chk("hold_busy", 32'(busy), 1);
        pause = 1'b0; start = 1'b1; cyc(1); start = 1'b0;
        chk("resume_edge", 32'(count), 7);
        cyc(1);
        chk("resume_8", 32'(count), 8);
        cyc(3);
        chk("resume_11", 32'(count), 11);
        chk("resume_notick", 32'(tick), 0);
        cyc(1);
        chk("pause_tick", 32'(tick), 1);
        chk("pause_wraps", 32'(wraps), 2);

        // Config offered during RUN is ignored
        offer(5'd5, 8'd3, 1'b1);
        chk("run_ready", 32'(cfg_ready), 0);
        cyc(1);
        cfg_valid = 1'b0;
        chk("run_noerr", 32'(cfg_err), 0);
        chk("run_count", 32'(count), 1);

        // stop + pause + start together
        stop = 1'b1; pause = 1'b1; start = 1'b1; cyc(1);
        stop = 1'b0; pause = 1'b0; start = 1'b0;
        chk("stop_busy", 32'(busy), 0);
        chk("stop_count", 32'(count), 0);
        chk("stop_wraps", 32'(wraps), 0);
        chk("stop_ready", 32'(cfg_ready), 1);

        // Three rejected configs
        offer(5'd1, 8'd0, 1'b0); cyc(1);
        chk("rej_n1", 32'(cfg_err), 1);
        offer(5'd17, 8'd0, 1'b0); cyc(1);
        chk("rej_n17", 32'(cfg_err), 1);
        offer(5'd5, 8'd0, 1'b1); cyc(1);
        chk("rej_reps0", 32'(cfg_err), 1);
        cfg_valid = 1'b0; cyc(1);
        chk("rej_clear", 32'(cfg_err), 0);

        // Period still 12, not one-shot
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(11);
        chk("keep12_11", 32'(count), 11);
        chk("keep12_notick", 32'(tick), 0);
        cyc(1);
        chk("keep12_tick", 32'(tick), 1);
        chk("keep12_done", 32'(done), 0);

        // One-shot n=5 reps=3
        stop = 1'b1; cyc(1); stop = 1'b0;
        offer(5'd5, 8'd3, 1'b1); cyc(1); cfg_valid = 1'b0;
        chk("os_acc_err", 32'(cfg_err), 0);
        start = 1'b1; cyc(1); start = 1'b0;
        for (int w = 1; w <= 3; w++) begin
            cyc(4);
            chk("os_c4", 32'(count), 4);
            chk("os_notick", 32'(tick), 0);
            cyc(1);
            chk("os_tick", 32'(tick), 1);
            chk("os_wraps", 32'(wraps), 32'(w));
        end
        chk("os_done", 32'(done), 1);
        chk("os_busy", 32'(busy), 0);
        chk("os_ready", 32'(cfg_ready), 1);
        chk("os_count", 32'(count), 0);
        cyc(2);
        chk("os_done_hold", 32'(done), 1);
        chk("os_wraps_hold", 32'(wraps), 3);
        chk("os_tick_off", 32'(tick), 0);
        chk("os_count_hold", 32'(count), 0);

        // Config + start from DONE: config wins, lands in IDLE
        offer(5'd2, 8'd0, 1'b0); start = 1'b1; cyc(1);
        cfg_valid = 1'b0; start = 1'b0;
        chk("cfgwin_done", 32'(done), 0);
        chk("cfgwin_busy", 32'(busy), 0);
        chk("cfgwin_wraps", 32'(wraps), 0);

        // n=2 toggles
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(1);
        chk("n2_c1", 32'(count), 1);
        chk("n2_notick", 32'(tick), 0);
        cyc(1);
        chk("n2_c0", 32'(count), 0);
        chk("n2_tick", 32'(tick), 1);
        cyc(2);
        chk("n2_tick2", 32'(tick), 1);
        chk("n2_wraps", 32'(wraps), 2);

        // n=16 wraps naturally
        stop = 1'b1; cyc(1); stop = 1'b0;
        offer(5'd16, 8'd0, 1'b0); cyc(1); cfg_valid = 1'b0;
        chk("n16_err", 32'(cfg_err), 0);
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(15);
        chk("n16_c15", 32'(count), 15);
        chk("n16_notick", 32'(tick), 0);
        cyc(1);
        chk("n16_c0", 32'(count), 0);
        chk("n16_tick", 32'(tick), 1);

        // Reset mid-run at count 9 restores defaults
        cyc(9);
        chk("mid_c9", 32'(count), 9);
        reset = 1'b0; cyc(1);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_wraps", 32'(wraps), 0);
        reset = 1'b1;
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(11);
        chk("mid_n12_11", 32'(count), 11);
        cyc(1);
        chk("mid_n12_tick", 32'(tick), 1);

`ifdef MODN_SEQ_PRESCALE_EN
        // Prescale by 3 with n=4: tick every 12 cycles
        stop = 1'b1; cyc(1); stop = 1'b0;
        cfg_div = 8'd2; offer(5'd4, 8'd0, 1'b0); cyc(1); cfg_valid = 1'b0;
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(2);
        chk("pre_c0", 32'(count), 0);
        cyc(1);
        chk("pre_c1", 32'(count), 1);
        cyc(8);
        chk("pre_notick", 32'(tick), 0);
        cyc(1);
        chk("pre_tick", 32'(tick), 1);
        chk("pre_count", 32'(count), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/modn_seq_ctrl.md
Name: modn_seq_ctrl

Overview:
- Run-time controller for a mod-N counter datapath.
- Accepts a modulus/repeat configuration over a valid/ready handshake.
- Sequences the count through start/pause/stop commands, emits a wrap tick, tracks completed wraps, and terminates one-shot runs.
- Sits between the system control/register interface and timing consumers that need programmable periodic or burst events.

Parameters:
- WIDTH, 4, width of count and modulus.
- DEFAULT_N, 12, modulus loaded at reset; legal range 2..2**WIDTH.
- REP_W, 8, width of the repeat count and the wrap counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  config can be accepted (IDLE or DONE only).
- cfg_n  in  WIDTH+1  requested modulus.
- cfg_reps  in  REP_W  wraps per one-shot run.
- cfg_oneshot  in  1  1 = stop after cfg_reps wraps; 0 = free-run.
- start  in  1  begin run, or resume from HOLD.
- pause  in  1  freeze count.
- stop  in  1  abort to IDLE.
- count  out  WIDTH  current count.
- tick  out  1  one-cycle pulse, high in the cycle count shows 0 after a wrap.
- wraps  out  REP_W  wraps completed in current run; saturates at all-ones.
- busy  out  1  state is RUN or HOLD.
- done  out  1  state is DONE (level).
- cfg_err  out  1  one-cycle pulse when an offered config is rejected.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE, count=0, tick=0, wraps=0, done=0, busy=0, cfg_err=0.
  - n_reg=DEFAULT_N, reps_reg=0, oneshot_reg=0.
- Config handshake:
  - Transfer occurs when cfg_valid & cfg_ready at the edge.
  - Rejection: cfg_n<2, cfg_n>2**WIDTH, or cfg_oneshot=1 with cfg_reps=0. On rejection cfg_err pulses next cycle and registers are unchanged.
  - On acceptance registers update next cycle. DONE→IDLE, count=0, wraps=0.
  - cfg_ready=0 in RUN/HOLD; cfg_valid is ignored there and no error is raised.
- Command priority, same cycle: stop > pause > start. Config transfer and start in the same cycle: config wins, start ignored.
- IDLE:
  - start → RUN with count=0, wraps=0.
  - pause/stop: no effect.
- RUN:
  - Each cycle, count = (count==n_reg-1) ? 0 : count+1.
  - On wrap: tick=1 next cycle and wraps increments (saturating).
  - pause → HOLD; count frozen at its current value, no tick.
  - stop → IDLE; count=0, wraps=0.
  - oneshot_reg=1 and the wrap making wraps==reps_reg → DONE. count=0 and tick=1 on the entry cycle.
- HOLD:
  - start (without pause/stop) → RUN; counting resumes from the held value on the next edge.
  - pause held: stay in HOLD.
  - stop → IDLE.
- DONE:
  - count=0, wraps holds the final value, done=1.
  - start → RUN with fresh wraps=0.
  - stop → IDLE.
- Latency: command to state change is 1 cycle. First increment appears 1 cycle after the RUN edge. First tick comes n_reg cycles after start is sampled.
- Boundaries:
  - n_reg=2 toggles 0/1 with a tick every 2 cycles.
  - n_reg=2**WIDTH wraps naturally.
  - reset low mid-run overrides everything at that edge.

Optional Feature:
- Macro: MODN_SEQ_PRESCALE_EN.
- Defined:
  - Adds input cfg_div[7:0], captured with each accepted config; reset value 0.
  - An internal prescaler advances count once every cfg_div+1 RUN cycles.
  - Prescaler clears on start-from-IDLE/DONE and on stop. It freezes in HOLD.
  - tick still marks count returning to 0.
- Undefined:
  - No cfg_div port; count advances every RUN cycle (equivalent to cfg_div=0).

Decomposition:
- Shared package modn_pkg:
  - State enum: IDLE, RUN, HOLD, DONE.
  - Minimum legal modulus constant: 2.
  - Config-validity check function.
- Sub-module modn_core holds the datapath:
  - Inputs: en, clr, n.
  - Outputs: count, wrap pulse.
  - Synchronous clear; wraps at n-1.
- modn_seq_ctrl holds the FSM, config registers, wrap counter and handshake.

Test Plan:
- Reset then start with the default config → count runs 0..11,0. First tick 12 cycles after start; wraps=1 after the first tick; done stays 0.
- Config cfg_n=5, cfg_reps=3, oneshot=1, then start → exactly 3 ticks at 5-cycle spacing, then DONE. count=0, wraps=3, done=1, cfg_ready=1.
- Offer cfg_n=1, then cfg_n=17 (WIDTH=4), then oneshot with reps=0 → three cfg_err pulses; n_reg still 12 (verify by run period).
- Pause at count=7 for 4 cycles, then start → count holds 7 with no tick, resumes at 8. Tick spacing extends by exactly 4 cycles.
- stop+pause+start asserted together in RUN → IDLE, count=0, wraps=0. Offer cfg_valid in RUN → cfg_ready=0, no transfer.
- reset low at count=9 mid-run → next edge count=0, IDLE, n_reg=12. With MODN_SEQ_PRESCALE_EN and cfg_div=2, cfg_n=4 → tick every 12 cycles.
